// File: rtl/counter_bank_reader_pkg.sv
// Shared types and helpers for the counter bank reader: FSM state encoding
// and the beat-index width derivation.
package counter_bank_reader_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  function automatic int idx_width(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/counter_bank_reader.sv
// Snapshots a bank of free-running counters in one cycle and streams the
// captured values out, one beat per counter, over a valid/ready interface.
module counter_bank_reader
  import counter_bank_reader_pkg::*;
#(
  parameter  int NUM_CNT   = 8,
  parameter  int CNT_WIDTH = 32,
  localparam int IDX_W     = idx_width(NUM_CNT)
) (
  input  logic                         clock,
  input  logic                         aclr_n,
  input  logic [NUM_CNT*CNT_WIDTH-1:0] cnt_in,
  input  logic                         snap_req,
  input  logic                         clr_on_read,
  output logic                         cnt_sclr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CNT_WIDTH-1:0]         out_data,
  output logic [IDX_W-1:0]             out_idx,
  output logic                         out_last,
  output logic                         busy,
  output logic                         req_dropped,
  input  logic                         drop_clr
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CNT - 1);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CNT_WIDTH-1:0]   snap_q [NUM_CNT];
  logic [CNT_WIDTH-1:0]   snap_d [NUM_CNT];
  logic                   drop_q, drop_d;
  logic                   sending_s;
  logic                   last_s;
  logic [CNT_WIDTH-1:0]   data_s;

  assign sending_s = (state_q == SEND);
  assign last_s    = sending_s && (idx_q == LAST_IDX);

  // Next-state logic: capture on an idle request, advance the index per handshake.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    case (state_q)
      IDLE: begin
        if (snap_req) begin
          state_d = SEND;
          idx_d   = '0;
          for (int i = 0; i < NUM_CNT; i++) begin
            snap_d[i] = cnt_in[i*CNT_WIDTH +: CNT_WIDTH];
          end
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          state_d = SEND;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A request landing while streaming sets the sticky flag, and wins over drop_clr.
  always_comb begin
    drop_d = drop_q;
    if (snap_req && sending_s) begin
      drop_d = 1'b1;
    end else if (drop_clr) begin
      drop_d = 1'b0;
    end else begin
      drop_d = drop_q;
    end
  end

  // Beat data mux; outside a stream the data bus is held at zero.
  always_comb begin
    data_s = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (sending_s && (idx_q == IDX_W'(i))) begin
        data_s = snap_q[i];
      end else begin
        data_s = data_s;
      end
    end
  end

  // State, index, sticky flag and snapshot registers.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      drop_q  <= 1'b0;
      for (int i = 0; i < NUM_CNT; i++) begin
        snap_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drop_q  <= drop_d;
      snap_q  <= snap_d;
    end
  end

  // The clear is issued on the capture edge itself so no count is read twice.
  assign cnt_sclr    = snap_req & (state_q == IDLE) & clr_on_read;
  assign out_valid   = sending_s;
  assign busy        = sending_s;
  assign out_last    = last_s;
  assign out_idx     = sending_s ? idx_q : '0;
  assign out_data    = data_s;
  assign req_dropped = drop_q;

endmodule
